// File: rtl/ntt_stage_scheduler_pkg.sv
// Shared constants and state type for the NTT stage scheduler and its index decoder.
package ntt_pkg;

  localparam int LOGN          = 10;
  localparam int BFU_NUM       = 4;
  localparam int CYC_PER_STAGE = (1 << LOGN) / (2 * BFU_NUM);

  localparam int CNT_W = 7;
  localparam int IDX_W = 9;
  localparam int P_W   = 4;

  typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} sched_state_t;

endpackage

// File: rtl/ntt_index_decode.sv
// Combinational (cnt, p) -> (k, i) split of the in-stage cycle index into group / intra-group parts.
module ntt_index_decode
  import ntt_pkg::*;
(
  input  logic [CNT_W-1:0] cnt,
  input  logic [P_W-1:0]   p,
  output logic [IDX_W-1:0] k,
  output logic [IDX_W-1:0] i
);

  logic [IDX_W-1:0] cnt_ext;
  logic [IDX_W-1:0] mask;
  logic [P_W-1:0]   sh;

  // J/4 = 1 << (p-2), so mod/div reduce to a mask and a shift
  always_comb begin
    cnt_ext = IDX_W'(cnt);
    sh      = p - P_W'(2);
    mask    = (IDX_W'(1) << sh) - IDX_W'(1);
    if (p >= P_W'(2)) begin
      k = cnt_ext >> sh;
      i = cnt_ext & mask;
    end else begin
      k = cnt_ext;
      i = '0;
    end
  end

endmodule

// File: rtl/ntt_stage_scheduler.sv
// Stage/cycle sequencer for the 4-BFU NTT/INTT address generator: RUN each stage, drain GAP, DONE pulse.
module ntt_stage_scheduler #(
  parameter int LOGN    = ntt_pkg::LOGN,
  parameter int BFU_NUM = ntt_pkg::BFU_NUM,
  parameter int GAP_CYC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mode_intt,
  input  logic       rev_en,
  input  logic       stall,
  output logic       busy,
  output logic       done,
  output logic       addr_valid,
  output logic [8:0] k,
  output logic [8:0] i,
  output logic [3:0] p,
  output logic [6:0] cnt_addr_gen,
  output logic       ntt_flag,
  output logic       rev,
  output logic       stage_last
);

  import ntt_pkg::*;

  localparam int               CYC      = (1 << LOGN) / (2 * BFU_NUM);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYC - 1);
  localparam int               GW       = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GW-1:0]    GAP_LAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [P_W-1:0]   P_TOP    = P_W'(LOGN - 1);

  sched_state_t     state;
  logic [GW-1:0]    gap_cnt;
  logic [CNT_W-1:0] dec_cnt;
  logic [P_W-1:0]   dec_p;
  logic [P_W-1:0]   p_step;
  logic [IDX_W-1:0] dec_k;
  logic [IDX_W-1:0] dec_i;
  logic             cnt_wrap;
  logic             stage_is_last;

  assign p_step        = ntt_flag ? p + 1'b1 : p - 1'b1;
  assign stage_is_last = ntt_flag ? (p == P_TOP) : (p == '0);
  assign cnt_wrap      = (cnt_addr_gen == CNT_LAST);
  assign addr_valid    = (state == RUN) && !stall;

  // Index the decoder with the values the registers will hold after this edge
  always_comb begin
    dec_cnt = '0;
    dec_p   = p;
    case (state)
      IDLE: dec_p = mode_intt ? '0 : P_TOP;
      RUN: begin
        dec_cnt = cnt_wrap ? '0 : cnt_addr_gen + 1'b1;
        dec_p   = cnt_wrap ? p_step : p;
      end
      GAP:     dec_p = p_step;
      default: dec_p = p;
    endcase
  end

  ntt_index_decode u_decode (
    .cnt (dec_cnt),
    .p   (dec_p),
    .k   (dec_k),
    .i   (dec_i)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      gap_cnt      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      k            <= '0;
      i            <= '0;
      p            <= '0;
      cnt_addr_gen <= '0;
      ntt_flag     <= 1'b0;
      rev          <= 1'b0;
      stage_last   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= RUN;
            busy         <= 1'b1;
            ntt_flag     <= mode_intt;
            rev          <= rev_en;
            p            <= dec_p;
            cnt_addr_gen <= dec_cnt;
            k            <= dec_k;
            i            <= dec_i;
            stage_last   <= 1'b0;
          end
        end
        RUN: begin
          if (!stall) begin
            if (!cnt_wrap) begin
              cnt_addr_gen <= dec_cnt;
              k            <= dec_k;
              i            <= dec_i;
              stage_last   <= stage_is_last && (dec_cnt == CNT_LAST);
            end else begin
              rev        <= 1'b0;
              stage_last <= 1'b0;
              if (GAP_CYC > 0) begin
                state   <= GAP;
                gap_cnt <= '0;
              end else if (stage_is_last) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                cnt_addr_gen <= dec_cnt;
                p            <= dec_p;
                k            <= dec_k;
                i            <= dec_i;
              end
            end
          end
        end
        // Drain gap runs a fixed length; back-pressure does not stretch it
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (stage_is_last) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state        <= RUN;
              cnt_addr_gen <= dec_cnt;
              p            <= dec_p;
              k            <= dec_k;
              i            <= dec_i;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state        <= IDLE;
          busy         <= 1'b0;
          k            <= '0;
          i            <= '0;
          p            <= '0;
          cnt_addr_gen <= '0;
          ntt_flag     <= 1'b0;
          rev          <= 1'b0;
          stage_last   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_stage_scheduler.sv
// Bench for ntt_stage_scheduler: queue-based schedule model plus directed literal checks.
module tb_ntt_stage_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, mode_intt, rev_en, stall;
  logic       busy, done, addr_valid, ntt_flag, rev, stage_last;
  logic [8:0] k, i;
  logic [3:0] p;
  logic [6:0] cnt_addr_gen;

  logic       start1, mode1, rev1, stall1;
  logic       busy1, done1, addr_valid1, ntt_flag1, rev1_o, stage_last1;
  logic [8:0] k1, i1;
  logic [3:0] p1;
  logic [6:0] cnt1;

  always #5 clk = ~clk;

  ntt_stage_scheduler #(.LOGN(10), .BFU_NUM(4), .GAP_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode_intt(mode_intt), .rev_en(rev_en),
    .stall(stall), .busy(busy), .done(done), .addr_valid(addr_valid), .k(k), .i(i),
    .p(p), .cnt_addr_gen(cnt_addr_gen), .ntt_flag(ntt_flag), .rev(rev),
    .stage_last(stage_last)
  );

  ntt_stage_scheduler #(.LOGN(10), .BFU_NUM(4), .GAP_CYC(0)) dut_nogap (
    .clk(clk), .rst_n(rst_n), .start(start1), .mode_intt(mode1), .rev_en(rev1),
    .stall(stall1), .busy(busy1), .done(done1), .addr_valid(addr_valid1), .k(k1), .i(i1),
    .p(p1), .cnt_addr_gen(cnt1), .ntt_flag(ntt_flag1), .rev(rev1_o),
    .stage_last(stage_last1)
  );

  typedef struct {
    int  pp;
    int  c;
    int  kk;
    int  ii;
    bit  rv;
    bit  last;
    bit  flag;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   busy_cnt, done_cnt, rev_cnt;
  bit   mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: condition not reached (t=%0t)", nm, $time);
  endtask

  // Schedule straight from the stage-order and mod/div rules
  task automatic load_model(input bit intt, input bit re);
    q.delete();
    for (int s = 0; s < 10; s++) begin
      int pp;
      int quarter;
      pp = intt ? s : 9 - s;
      quarter = (1 << pp) / 4;
      for (int c = 0; c < 128; c++) begin
        exp_t e;
        e.pp = pp;
        e.c  = c;
        if (pp >= 2) begin
          e.kk = c / quarter;
          e.ii = c % quarter;
        end else begin
          e.kk = c;
          e.ii = 0;
        end
        e.rv   = re && (s == 0);
        e.last = (s == 9) && (c == 127);
        e.flag = intt;
        q.push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (rev) rev_cnt++;
      if (stall) chk("valid_under_stall", addr_valid, 0);
      if (addr_valid) begin
        if (q.size() == 0) begin
          fail_now("model_exhausted");
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("m_p", p, e.pp);
          chk("m_cnt", cnt_addr_gen, e.c);
          chk("m_k", k, e.kk);
          chk("m_i", i, e.ii);
          chk("m_rev", rev, e.rv);
          chk("m_last", stage_last, e.last);
          chk("m_flag", ntt_flag, e.flag);
          chk("m_busy", busy, 1);
        end
      end
    end
  end

  task automatic start_run(input bit intt, input bit re);
    load_model(intt, re);
    busy_cnt = 0;
    done_cnt = 0;
    rev_cnt  = 0;
    @(posedge clk); #1;
    start = 1'b1; mode_intt = intt; rev_en = re;
    @(posedge clk); #1;
    start = 1'b0; mode_intt = 1'b0; rev_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_for(input int wp, input int wc, input string nm);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 3000 && !ok; n++) begin
      @(negedge clk);
      if (addr_valid && p == wp[3:0] && cnt_addr_gen == wc[6:0]) ok = 1'b1;
    end
    if (!ok) fail_now(nm);
  endtask

  task automatic wait_done(input string nm);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 3000 && !ok; n++) begin
      @(negedge clk);
      if (done) ok = 1'b1;
    end
    if (!ok) fail_now(nm);
  endtask

  task automatic check_idle(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_valid"}, addr_valid, 0);
    chk({nm, "_p"}, p, 0);
    chk({nm, "_cnt"}, cnt_addr_gen, 0);
    chk({nm, "_k"}, k, 0);
    chk({nm, "_i"}, i, 0);
    chk({nm, "_flag"}, ntt_flag, 0);
    chk({nm, "_rev"}, rev, 0);
    chk({nm, "_last"}, stage_last, 0);
  endtask

  initial begin
    int b1, bub, v1;
    bit got;
    rst_n = 1'b0;
    start = 1'b0; mode_intt = 1'b0; rev_en = 1'b0; stall = 1'b0;
    start1 = 1'b0; mode1 = 1'b0; rev1 = 1'b0; stall1 = 1'b0;
    busy_cnt = 0; done_cnt = 0; rev_cnt = 0;
    #23;
    check_idle("reset");
    chk("reset_busy1", busy1, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // NTT run with a 3-cycle stall in stage p=4
    start_run(1'b0, 1'b0);
    chk("ntt_first_p", p, 9);
    chk("ntt_first_cnt", cnt_addr_gen, 0);
    chk("ntt_first_k", k, 0);
    chk("ntt_first_i", i, 0);
    chk("ntt_first_busy", busy, 1);
    wait_for(9, 127, "ntt_p9_c127");
    chk("ntt_c127_k", k, 0);
    chk("ntt_c127_i", i, 127);
    wait_for(4, 9, "ntt_p4_c9");
    @(posedge clk); #1;
    stall = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("stall_valid", addr_valid, 0);
      chk("stall_cnt", cnt_addr_gen, 10);
      chk("stall_k", k, 2);
      chk("stall_i", i, 2);
      @(posedge clk);
    end
    #1 stall = 1'b0;
    @(negedge clk);
    chk("resume_valid", addr_valid, 1);
    chk("resume_cnt", cnt_addr_gen, 10);
    @(negedge clk);
    chk("resume_cnt_next", cnt_addr_gen, 11);
    wait_for(2, 37, "ntt_p2_c37");
    chk("p2_k", k, 37);
    chk("p2_i", i, 0);
    wait_done("ntt_done");
    @(negedge clk);
    chk("ntt_busy_len", busy_cnt, 1324);
    chk("ntt_done_cnt", done_cnt, 1);
    chk("ntt_rev_cnt", rev_cnt, 0);
    chk("ntt_q_left", q.size(), 0);
    check_idle("ntt_idle");

    // INTT run with bit-reverse on the first stage
    start_run(1'b1, 1'b1);
    chk("intt_first_p", p, 0);
    chk("intt_flag", ntt_flag, 1);
    chk("intt_first_rev", rev, 1);
    wait_for(0, 127, "intt_p0_c127");
    @(negedge clk);
    chk("gap_valid", addr_valid, 0);
    chk("gap_rev", rev, 0);
    wait_for(9, 5, "intt_p9_c5");
    chk("intt_p9_k", k, 0);
    chk("intt_p9_i", i, 5);
    wait_for(9, 127, "intt_p9_c127");
    chk("intt_stage_last", stage_last, 1);
    wait_done("intt_done");
    @(negedge clk);
    chk("intt_busy_len", busy_cnt, 1321);
    chk("intt_rev_cnt", rev_cnt, 128);
    chk("intt_done_cnt", done_cnt, 1);
    chk("intt_q_left", q.size(), 0);

    // Asynchronous reset in the middle of stage p=3
    start_run(1'b0, 1'b0);
    wait_for(3, 40, "rst_p3_c40");
    #2 rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    start_run(1'b0, 1'b0);
    chk("restart_p", p, 9);
    chk("restart_cnt", cnt_addr_gen, 0);
    chk("restart_valid", addr_valid, 1);
    wait_done("restart_done");
    @(negedge clk);
    chk("restart_busy_len", busy_cnt, 1321);
    chk("restart_q_left", q.size(), 0);

    // Zero-gap build: back-to-back stages, stray starts ignored
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    b1 = 0; bub = 0; v1 = 0; got = 1'b0;
    for (int n = 0; n < 3000 && !got; n++) begin
      @(negedge clk);
      if (n == 0) begin
        chk("nogap_first_p", p1, 9);
        chk("nogap_first_cnt", cnt1, 0);
      end
      if (busy1) b1++;
      if (addr_valid1) v1++;
      if (busy1 && !done1 && !addr_valid1) bub++;
      start1 = (n == 600) || (n == 129);
      if (done1) begin
        got = 1'b1;
        start1 = 1'b1;
      end
    end
    if (!got) fail_now("nogap_done");
    @(negedge clk);
    start1 = 1'b0;
    chk("nogap_busy_len", b1, 1281);
    chk("nogap_valid_cnt", v1, 1280);
    chk("nogap_bubbles", bub, 0);
    chk("nogap_start_in_done", busy1, 0);
    @(negedge clk);
    chk("nogap_idle", busy1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
